// File: rtl/curr_block_feeder.sv
// curr_block_feeder: streams current-block pixel pairs from the block buffer
// into the PE chain, CB1/CB2 phase first, then CB3/CB4 phase.
module curr_block_feeder #(
  parameter int PIXEL  = 8,
  parameter int ROWS   = 8,
  parameter int ADDR_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic                 hold,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [2*PIXEL-1:0]   mem_rdata,
  output logic [PIXEL-1:0]     in_curr1,
  output logic [PIXEL-1:0]     in_curr2,
  output logic                 in_curr_enable,
  output logic                 CB_select,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(2*ROWS) + 1;
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(2*ROWS - 1);
  localparam logic [CNT_W-1:0] HALF_K = CNT_W'(ROWS);

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;

  state_t              state;
  logic [CNT_W-1:0]    k;
  logic [ADDR_W-1:0]   base_q;
  logic                issue;
  logic                rd_valid;
  logic                rd_tag;

  // Issue is combinational on hold so a stalled cycle never strobes the buffer.
  assign issue     = (state == ISSUE) && !hold;
  assign mem_rd_en = issue;
  assign mem_addr  = base_q + ADDR_W'(k);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      k      <= '0;
      base_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            k      <= '0;
            busy   <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (!hold) begin
            k <= k + CNT_W'(1);
            if (k == LAST_K) state <= FLUSH;
          end
        end
        FLUSH: begin
          // The final issued word is in the capture stage until rd_valid drops.
          if (!rd_valid) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid       <= 1'b0;
      rd_tag         <= 1'b0;
      in_curr_enable <= 1'b0;
      in_curr1       <= '0;
      in_curr2       <= '0;
      CB_select      <= 1'b0;
    end else begin
      rd_valid       <= issue;
      rd_tag         <= (k < HALF_K);
      in_curr_enable <= rd_valid;
      if (rd_valid) begin
        in_curr1  <= mem_rdata[PIXEL-1:0];
        in_curr2  <= mem_rdata[2*PIXEL-1:PIXEL];
        CB_select <= rd_tag;
      end
    end
  end

endmodule

// File: tb/tb_curr_block_feeder.sv
// Bench for curr_block_feeder: per-cycle expectation tables built from the
// load rules, a buffer model, and an 8-PE chain scoreboard checked at done.
module tb_curr_block_feeder;

  localparam int PIXEL   = 8;
  localparam int ROWS    = 8;
  localparam int ADDR_W  = 6;
  localparam int NCYC    = 256;
  localparam int END_CYC = 190;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              hold = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata = '0;
  logic [7:0]        in_curr1;
  logic [7:0]        in_curr2;
  logic              in_curr_enable;
  logic              CB_select;
  logic              busy;
  logic              done;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  bit model_ready = 1'b0;

  bit          stim_rst[NCYC];
  bit          stim_start[NCYC];
  bit          stim_hold[NCYC];
  logic [5:0]  stim_base[NCYC];

  bit          exp_rd[NCYC];
  logic [5:0]  exp_addr[NCYC];
  bit          exp_en[NCYC];
  logic [15:0] exp_data_ev[NCYC];
  bit          exp_sel_ev[NCYC];
  logic [15:0] exp_pix[NCYC];
  bit          exp_sel[NCYC];
  bit          exp_busy[NCYC];
  bit          exp_done[NCYC];
  bit          exp_rst[NCYC];
  int          done_base[NCYC];

  logic [15:0] mem[64];
  logic [15:0] chain_ab[ROWS];
  logic [15:0] chain_cd[ROWS];

  curr_block_feeder #(.PIXEL(PIXEL), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .hold(hold),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .in_curr1(in_curr1), .in_curr2(in_curr2), .in_curr_enable(in_curr_enable),
    .CB_select(CB_select), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic applyStimulus(input int c);
    rst_n     = !stim_rst[c];
    start     = stim_start[c];
    hold      = stim_hold[c];
    base_addr = stim_base[c];
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // One load: reads issue on every non-held cycle after start until 2*ROWS words go out.
  task automatic buildLoad(input int s, input int base);
    int n = 0;
    int c = s + 1;
    int last = s + 1;
    stim_start[s] = 1'b1;
    stim_base[s]  = 6'(base);
    while (n < 2*ROWS) begin
      if (!stim_hold[c]) begin
        exp_rd[c]        = 1'b1;
        exp_addr[c]      = 6'((base + n) % 64);
        exp_en[c+2]      = 1'b1;
        exp_data_ev[c+2] = mem[(base + n) % 64];
        exp_sel_ev[c+2]  = (n < ROWS);
        last = c;
        n++;
      end
      c++;
    end
    for (int b = s + 1; b <= last + 2; b++) exp_busy[b] = 1'b1;
    exp_done[last+3]  = 1'b1;
    done_base[last+3] = base;
  endtask

  task automatic applyReset(input int r, input int rel);
    for (int c = r; c < NCYC; c++) begin
      exp_rd[c]   = 1'b0;
      exp_addr[c] = '0;
      exp_en[c]   = 1'b0;
      exp_busy[c] = 1'b0;
      exp_done[c] = 1'b0;
    end
    for (int c = r; c < rel; c++) begin
      exp_rst[c]  = 1'b1;
      stim_rst[c] = 1'b1;
    end
  endtask

  task automatic finalizeModel();
    logic [15:0] cur_pix = '0;
    bit          cur_sel = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      if (exp_rst[c]) begin
        cur_pix = '0;
        cur_sel = 1'b0;
      end else if (exp_en[c]) begin
        cur_pix = exp_data_ev[c];
        cur_sel = exp_sel_ev[c];
      end
      exp_pix[c] = cur_pix;
      exp_sel[c] = cur_sel;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (cyc < NCYC) applyStimulus(cyc);
  end

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  // PE chain: word 0 of each phase travels all the way to PE ROWS-1.
  always @(posedge clk) begin
    if (in_curr_enable) begin
      if (CB_select) begin
        for (int j = ROWS - 1; j > 0; j--) chain_ab[j] <= chain_ab[j-1];
        chain_ab[0] <= {in_curr2, in_curr1};
      end else begin
        for (int j = ROWS - 1; j > 0; j--) chain_cd[j] <= chain_cd[j-1];
        chain_cd[0] <= {in_curr2, in_curr1};
      end
    end
  end

  always @(negedge clk) begin
    if (model_ready && cyc >= 1 && cyc < END_CYC) begin
      checkOutput("mem_rd_en", 32'(mem_rd_en), 32'(exp_rd[cyc]));
      if (exp_rd[cyc] || exp_rst[cyc])
        checkOutput("mem_addr", 32'(mem_addr), 32'(exp_addr[cyc]));
      checkOutput("in_curr_enable", 32'(in_curr_enable), 32'(exp_en[cyc]));
      checkOutput("in_curr1", 32'(in_curr1), 32'(exp_pix[cyc][7:0]));
      checkOutput("in_curr2", 32'(in_curr2), 32'(exp_pix[cyc][15:8]));
      checkOutput("CB_select", 32'(CB_select), 32'(exp_sel[cyc]));
      checkOutput("busy", 32'(busy), 32'(exp_busy[cyc]));
      checkOutput("done", 32'(done), 32'(exp_done[cyc]));
      if (exp_done[cyc]) begin
        for (int j = 0; j < ROWS; j++) begin
          checkOutput("pe_cb12", 32'(chain_ab[j]), 32'(mem[(done_base[cyc] + ROWS - 1 - j) % 64]));
          checkOutput("pe_cb34", 32'(chain_cd[j]), 32'(mem[(done_base[cyc] + 2*ROWS - 1 - j) % 64]));
        end
      end
    end
  end

  // Hand-computed anchors that pin the model to the documented timing.
  always @(negedge clk) begin
    case (cyc)
      2:   begin
             checkOutput("lit_reset_addr", 32'(mem_addr), 32'd0);
             checkOutput("lit_reset_busy", 32'(busy), 32'd0);
           end
      8:   begin
             checkOutput("lit_first_c1", 32'(in_curr1), 32'd0);
             checkOutput("lit_first_c2", 32'(in_curr2), 32'd1);
             checkOutput("lit_first_sel", 32'(CB_select), 32'd1);
           end
      9:   checkOutput("lit_second_c1", 32'(in_curr1), 32'd2);
      23:  begin
             checkOutput("lit_last_c1", 32'(in_curr1), 32'd30);
             checkOutput("lit_last_c2", 32'(in_curr2), 32'd31);
             checkOutput("lit_last_sel", 32'(CB_select), 32'd0);
           end
      24:  checkOutput("lit_done_t1", 32'(done), 32'd1);
      51:  checkOutput("lit_nodone_t2", 32'(done), 32'd0);
      52:  checkOutput("lit_done_hold", 32'(done), 32'd1);
      64:  checkOutput("lit_addr_63", 32'(mem_addr), 32'd63);
      65:  checkOutput("lit_addr_wrap", 32'(mem_addr), 32'd0);
      110: begin
             checkOutput("lit_b2b_rd", 32'(mem_rd_en), 32'd1);
             checkOutput("lit_b2b_addr", 32'(mem_addr), 32'd20);
           end
      149: begin
             checkOutput("lit_rst_busy", 32'(busy), 32'd0);
             checkOutput("lit_rst_en", 32'(in_curr_enable), 32'd0);
             checkOutput("lit_rst_rd", 32'(mem_rd_en), 32'd0);
           end
      174: checkOutput("lit_done_t5", 32'(done), 32'd1);
      default: ;
    endcase
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {8'(2*i + 1), 8'(2*i)};
    for (int j = 0; j < ROWS; j++) begin
      chain_ab[j] = '0;
      chain_cd[j] = '0;
    end
    for (int c = 0; c < NCYC; c++) begin
      stim_base[c]   = 6'(c * 7);
      exp_addr[c]    = '0;
      exp_data_ev[c] = '0;
      done_base[c]   = 0;
    end
    applyReset(0, 3);

    buildLoad(5, 0);

    for (int c = 34; c <= 36; c++) stim_hold[c] = 1'b1;
    buildLoad(30, 0);

    for (int c = 56; c <= 58; c++) stim_hold[c] = 1'b1;
    for (int c = 77; c <= 80; c++) stim_hold[c] = 1'b1;
    buildLoad(60, 60);

    stim_start[95]  = 1'b1;
    stim_base[95]   = 6'd33;
    stim_start[100] = 1'b1;
    stim_base[100]  = 6'd33;
    buildLoad(90, 0);
    buildLoad(109, 20);

    buildLoad(140, 0);
    applyReset(149, 151);
    buildLoad(155, 5);

    finalizeModel();
    model_ready = 1'b1;

    while (cyc < END_CYC) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/curr_block_feeder.md
# curr_block_feeder

Transmit-side companion to the motion-estimation PE chain: reads current-block pixel pairs from the on-chip current-block buffer and shifts them into the PE array's current-pixel inputs (`in_curr1`/`in_curr2`, `in_curr_enable`, `CB_select`). Each load fills all PEs in two phases: the CB1/CB2 pair registers first, then the CB3/CB4 pair registers. It sits between the current-block SRAM and the first PE of each chain, and is started by the ME top-level controller once per current block.

## Interface
- `PIXEL`, 8, pixel width in bits
- `ROWS`, 8, PEs per chain; number of pair-shifts per phase (≥2)
- `ADDR_W`, 6, buffer address width
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle load request; ignored while `busy`=1
- `base_addr`  in  ADDR_W  first word address; sampled with `start`
- `hold`  in  1  stall request issue; in-flight read still delivered
- `mem_rd_en`  out  1  buffer read strobe
- `mem_addr`  out  ADDR_W  buffer read address
- `mem_rdata`  in  2*PIXEL  read data, valid exactly 1 cycle after `mem_rd_en`
- `in_curr1`  out  PIXEL  to PE: `mem_rdata[PIXEL-1:0]`
- `in_curr2`  out  PIXEL  to PE: `mem_rdata[2*PIXEL-1:PIXEL]`
- `in_curr_enable`  out  1  to PE: shift strobe
- `CB_select`  out  1  to PE: 1 = load CB1/CB2 registers, 0 = load CB3/CB4 registers
- `busy`  out  1  load in progress
- `done`  out  1  one-cycle pulse, load complete

## Operation
- FSM states: IDLE, ISSUE, FLUSH.
  - IDLE: on `start`, latch `base_addr`, clear issue counter `k`, go to ISSUE.
  - ISSUE: each cycle with `hold`=0, assert `mem_rd_en` with `mem_addr` = base+k (mod 2^ADDR_W), and increment `k`. On the issue of `k`=2*ROWS-1, go to FLUSH.
  - FLUSH: wait until the last word has been delivered and the output pipeline is empty, pulse `done`, then go to IDLE.
- Word order:
  - Words 0..ROWS-1 are tagged phase A (`CB_select`=1).
  - Words ROWS..2*ROWS-1 are tagged phase B (`CB_select`=0).
  - Word 0 of each phase ends in the farthest PE (index ROWS-1); the last word of each phase ends in PE 0.
- Delivery pipeline (per issued read):
  - Issue cycle: read valid + phase tag stage.
  - Next cycle: `mem_rdata` is captured into the output registers.
  - Following cycle: `in_curr1`/`in_curr2` carry the data, `CB_select` carries the word's tag, and `in_curr_enable`=1.
- No-delivery cycles: `in_curr_enable`=0; `in_curr1`/`in_curr2`/`CB_select` hold their last values (the PE mux output stays stable).
- `hold`=1 blocks only new issue. A read already issued is always delivered. `hold` in IDLE or FLUSH has no effect.
- `start` while `busy`=1 is ignored: no relatch, no restart.
- Reset at any time: all state and outputs go to their reset values immediately (async). A partially loaded array is the controller's problem; the feeder restarts cleanly on the next `start`.
- Counter width: clog2(2*ROWS)+1 bits. Address arithmetic is ADDR_W-bit modular (wrap-around, no error).

## Timing
- Reset values: `mem_rd_en`=0, `mem_addr`=0, `in_curr1`=0, `in_curr2`=0, `in_curr_enable`=0, `CB_select`=0, `busy`=0, `done`=0.
- `start` sampled at edge E0. Relative to E0, with no `hold`:
  - `busy`=1 from cycle 1.
  - Reads issue in cycles 1..2*ROWS.
  - `in_curr_enable` is high in cycles 3..2*ROWS+2.
  - `CB_select`=1 in cycles 3..ROWS+2 and 0 in cycles ROWS+3..2*ROWS+2.
  - `done`=1 in cycle 2*ROWS+3, with `busy`=0 in that same cycle.
- Each `hold` cycle during ISSUE adds exactly one cycle to the `done` latency.
- Back-to-back loads: a `start` in the cycle where `done`=1 is accepted. Its first read issues in the next cycle.
- The `in_curr_enable` pulse count per load is exactly 2*ROWS: ROWS pulses with `CB_select`=1, then ROWS with `CB_select`=0, never interleaved.

## Test plan
- Reset, then ROWS=8, `base_addr`=0, buffer word i = {8'(2i+1), 8'(2i)}, `start` -> 16 reads at addr 0..15 in cycles 1..16; enables in cycles 3..18 with `in_curr1`=0,2,4..30 and `in_curr2`=1,3..31; `CB_select`=1 for the first 8 enables, 0 for the last 8; `done` at cycle 19.
- Same load with `hold`=1 in cycles 4..6 -> addresses stay gap-free in sequence; 3 idle cycles appear in `in_curr_enable`; `done` at cycle 22; the read issued before the hold is still delivered.
- `base_addr`=60, ADDR_W=6 -> addresses 60,61,62,63,0,1..11; data order preserved.
- `start` pulses in cycles 5 and 10 during a load -> ignored, single `done` at 19; a `start` at cycle 19 -> new first read at cycle 20.
- `rst_n` low at cycle 9 mid-load -> all outputs 0 immediately, no `done`; a new `start` gives a full 16-word load.
- Scoreboard with an 8-PE chain model -> after `done`, PE j holds CB1/CB2 = words 7-j and CB3/CB4 = words 15-j.
